arb_grant_ctrl: RTL
===================

Name: arb_grant_ctrl

Overview:
Root controller for the 4-to-1 fixed-priority arbiter tree. It consumes the tree's aggregate request and one-hot grant vector, and drives the tree's Grant input for exactly one arbitration cycle. It registers the winner and holds that grant until the winner drops its request or a hold limit expires, then inserts one dead cycle before re-arbitrating. It sits directly above the root priority-encoder stage: its Tree_Grant_OUT feeds that stage's Grant input, and that stage's Grant/Request outputs feed back into this block.

Parameters:
N_REQ, 4, number of requesters; fixed at 4 to match the 4-to-1 encoder stage.
MAX_HOLD, 16, maximum consecutive OWN cycles per grant; 0 = unlimited.
CNT_W, 8, hold-counter width; MAX_HOLD must be < 2^CNT_W.

Ports:
CLK  input  1  single clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
Request_IN  input  4  raw request vector; the same vector drives the encoder's Request input.
Tree_Request_IN  input  1  encoder Request output (OR of requests).
Tree_Grant_IN  input  4  encoder one-hot Grant output; only meaningful while Tree_Grant_OUT=1.
Tree_Grant_OUT  output  1  drives encoder Grant input; high only in ARB.
Grant_OUT  output  4  registered one-hot grant to requesters.
Busy_OUT  output  1  high when state != IDLE.
Timeout_OUT  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, any state, mid-grant included) sets:
  - state=IDLE, Owner=0, Grant_OUT=0, hold count=0, Timeout_OUT=0.
  - Tree_Grant_OUT=0 and Busy_OUT=0; both are decoded from state.
- States: IDLE, ARB, OWN, GAP. Tree_Grant_OUT = (state==ARB). Busy_OUT = (state!=IDLE).
- IDLE: Tree_Request_IN=1 at edge -> ARB; else stay.
- ARB (exactly one cycle):
  - At the edge, Owner<=Tree_Grant_IN and Grant_OUT<=Tree_Grant_IN, count<=1, -> OWN.
  - If Tree_Grant_IN==0 (request withdrawn), -> IDLE with Grant_OUT unchanged at 0.
- Latency: request sampled high at edge k in IDLE -> Tree_Grant_OUT high during cycle k+1 -> Grant_OUT high after edge k+1 (2 edges).
- Tree_Grant_IN is ignored in every state except ARB. The encoder holds stale outputs while its Grant input is low; they must never be captured.
- OWN, evaluated at each edge, in priority order:
  1. Request_IN & Owner == 0 -> Grant_OUT<=0, -> GAP.
  2. MAX_HOLD!=0 and count==MAX_HOLD -> Grant_OUT<=0, Timeout_OUT<=1 for one cycle, -> GAP.
  3. Otherwise count<=count+1, stay in OWN.
  - Release wins if the drop and the limit coincide, so no Timeout_OUT pulse in that case.
  - count saturates at 2^CNT_W-1 when MAX_HOLD=0.
- Requests from non-owners never affect OWN. A higher-priority request does not preempt the owner.
- GAP (one dead cycle, Grant_OUT=0): Tree_Request_IN=1 -> ARB; else -> IDLE.
- Grant_OUT is always one-hot or zero; it never changes other than at IDLE/ARB/OWN/GAP transitions listed above.
- Max grant length with MAX_HOLD=M is exactly M cycles of Grant_OUT high.
- Timeout_OUT is registered and clears the cycle after the pulse.

Decomposition:
- Shared arbiter package holds: state encoding (IDLE=2'd0, ARB=2'd1, OWN=2'd2, GAP=2'd3), N_REQ=4, and the default MAX_HOLD.
- No sub-module; the encoder stage stays a separate instance in the parent.
- The bench instantiates the encoder plus this block together.

Test Plan:
- Single requester: Request_IN=4'b0100 from cycle 0, dropped at cycle 6 -> Tree_Grant_OUT high in cycle 1 only; Grant_OUT=4'b0100 cycles 2-6; GAP then IDLE; Busy_OUT low by cycle 8.
- Priority with no preemption:
  - Request_IN=4'b1000, then bit0 asserted once Grant_OUT=4'b1000 -> Grant_OUT stays 4'b1000 until bit3 drops.
  - One GAP cycle, then Grant_OUT=4'b0001.
- Timeout: MAX_HOLD=4, Request_IN=4'b0010 held high -> Grant_OUT high exactly 4 cycles; Timeout_OUT pulse in the following cycle; re-grant to 4'b0010 after GAP+ARB (2 cycles of Grant_OUT=0).
- Coincident release and limit: MAX_HOLD=3, request dropped so it is sampled low on the edge where count==3 -> GAP, Timeout_OUT stays 0.
- Withdrawn request: pulse Request_IN=4'b0001 for one cycle -> ARB sees Tree_Grant_IN=0 -> IDLE; Grant_OUT never asserts.
- Reset mid-grant: assert RESET asynchronously while Grant_OUT=4'b0100 -> Grant_OUT=0, Busy_OUT=0 immediately (before the next edge); after release, normal 2-edge grant latency.

Source files
------------

// File: rtl/arb_grant_ctrl_pkg.sv
// Shared definitions for the root grant controller of the 4-to-1 arbiter tree.
package arb_grant_ctrl_pkg;

   localparam int ARB_N_REQ        = 4;
   localparam int ARB_MAX_HOLD_DEF = 16;
   localparam int ARB_CNT_W_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      OWN  = 2'd2,
      GAP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/arb_grant_ctrl_if.sv
// Request/grant bundle between the root encoder stage, the requesters and the controller.
interface arb_grant_ctrl_if
   import arb_grant_ctrl_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ
) ();

   logic [N_REQ-1:0] Request_IN;
   logic             Tree_Request_IN;
   logic [N_REQ-1:0] Tree_Grant_IN;
   logic             Tree_Grant_OUT;
   logic [N_REQ-1:0] Grant_OUT;
   logic             Busy_OUT;
   logic             Timeout_OUT;

   // Controller side.
   modport slave (
      input  Request_IN, Tree_Request_IN, Tree_Grant_IN,
      output Tree_Grant_OUT, Grant_OUT, Busy_OUT, Timeout_OUT
   );

   // Encoder/requester side.
   modport master (
      output Request_IN, Tree_Request_IN, Tree_Grant_IN,
      input  Tree_Grant_OUT, Grant_OUT, Busy_OUT, Timeout_OUT
   );

endinterface

// File: rtl/arb_grant_ctrl.sv
// Root grant controller: enables the encoder for one cycle, latches the winner and
// holds its grant until release or hold-limit expiry, then forces one dead cycle.
module arb_grant_ctrl
   import arb_grant_ctrl_pkg::*;
#(
   parameter int N_REQ    = ARB_N_REQ,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
   parameter int CNT_W    = ARB_CNT_W_DEF
) (
   input  logic            CLK,
   input  logic            RESET,
   arb_grant_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_e       state;
   logic [N_REQ-1:0] owner;
   logic [N_REQ-1:0] grant;
   logic [CNT_W-1:0] cnt;
   logic             timeout;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         owner   <= '0;
         grant   <= '0;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         unique case (state)
            IDLE: if (bus.Tree_Request_IN) state <= ARB;
            // Only here is the encoder enabled, so only here is its grant trusted.
            ARB: begin
               if (bus.Tree_Grant_IN != '0) begin
                  owner <= bus.Tree_Grant_IN;
                  grant <= bus.Tree_Grant_IN;
                  cnt   <= CNT_W'(1);
                  state <= OWN;
               end else begin
                  state <= IDLE;
               end
            end
            // Release is checked before the limit so a coincident drop never pulses timeout.
            OWN: begin
               if ((bus.Request_IN & owner) == '0) begin
                  grant <= '0;
                  state <= GAP;
               end else if (MAX_HOLD != 0 && cnt == HOLD_LIM) begin
                  grant   <= '0;
                  timeout <= 1'b1;
                  state   <= GAP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            GAP: state <= bus.Tree_Request_IN ? ARB : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Tree_Grant_OUT = (state == ARB);
   assign bus.Busy_OUT       = (state != IDLE);
   assign bus.Grant_OUT      = grant;
   assign bus.Timeout_OUT    = timeout;

endmodule
